// File: rtl/fc_tx_framer_pkg.sv
// fc_tx_framer_pkg: FC-2 transmit primitives, CRC constants and framer FSM states
package fc_tx_framer_pkg;
  localparam logic [31:0] PRIM_IDLE  = 32'hBC95B5B5;
  localparam logic [31:0] PRIM_SOFI3 = 32'hBCB55656;
  localparam logic [31:0] PRIM_EOFN  = 32'hBC95D5D5;
  localparam logic [31:0] PRIM_EOFA  = 32'hBC95F5F5;
  localparam logic [3:0]  K_FLAG     = 4'b1000;
  localparam logic [3:0]  D_FLAG     = 4'b0000;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_R = 32'hEDB88320;
  typedef enum logic [2:0] {ST_GAP, ST_IDLE, ST_SOF, ST_DATA, ST_CRC, ST_EOF, ST_DRAIN} tx_state_t;
  // Complemented CRC with its low byte placed first on the wire
  function automatic logic [31:0] crc_wire(input logic [31:0] st);
    logic [31:0] c;
    c = ~st;
    return {c[7:0], c[15:8], c[23:16], c[31:24]};
  endfunction
endpackage

// File: rtl/fc_crc32.sv
// fc_crc32: one-word FC CRC-32 step, bytes MSB-first, bits LSB-first within each byte
module fc_crc32
  import fc_tx_framer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);
  logic [31:0] d;
  logic [7:0] by;
  always_comb begin
    crc_out = crc_in;
    d = data;
    by = '0;
    for (int b = 0; b < 4; b++) begin
      by = d[31:24];
      for (int k = 0; k < 8; k++) begin
        crc_out = {1'b0, crc_out[31:1]} ^ ((crc_out[0] ^ by[0]) ? CRC_POLY_R : 32'h0);
        by = {1'b0, by[7:1]};
      end
      d = {d[23:0], 8'h00};
    end
  end
endmodule

// File: rtl/fc_tx_framer.sv
// fc_tx_framer: wraps user frames in SOFi3/CRC/EOFn with an IDLE gap, or passes link-state words
module fc_tx_framer
  import fc_tx_framer_pkg::*;
#(
  parameter int MTU      = 3072,
  parameter int IDLE_GAP = 6
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] usertx_data,
  input  logic        usertx_valid,
  output logic        usertx_ready,
  input  logic        usertx_startofpacket,
  input  logic        usertx_endofpacket,
  input  logic [35:0] state_data,
  input  logic        link_active,
  output logic [35:0] avtx_data,
  output logic        avtx_valid,
  input  logic        avtx_ready,
  output logic [31:0] frames_sent,
  output logic [31:0] frames_aborted
);
  tx_state_t state;
  logic [15:0] gap;
  logic [31:0] crc, crc_next, len;
  logic [35:0] tx_word;
  logic sop_go, in_frame, over, eop_word;
  fc_crc32 u_crc (.crc_in(crc), .data(usertx_data), .crc_out(crc_next));
  assign sop_go   = usertx_valid & usertx_startofpacket & link_active;
  assign eop_word = usertx_valid & usertx_endofpacket;
  assign in_frame = state inside {ST_SOF, ST_DATA, ST_CRC, ST_EOF};
  assign over     = (len + 32'd4) > 32'(MTU);
  assign usertx_ready = avtx_ready & (state == ST_DATA | state == ST_DRAIN |
                                      (state == ST_IDLE & ~usertx_startofpacket));
  always_comb begin
    tx_word = state == ST_SOF  ? {K_FLAG, PRIM_SOFI3} :
              state == ST_DATA ? ((usertx_valid & ~over) ? {D_FLAG, usertx_data} : {K_FLAG, PRIM_EOFA}) :
              state == ST_CRC  ? {D_FLAG, crc_wire(crc)} :
              state == ST_EOF  ? {K_FLAG, PRIM_EOFN} : {K_FLAG, PRIM_IDLE};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_GAP;
      gap            <= 16'(IDLE_GAP);
      crc            <= CRC_INIT;
      len            <= '0;
      avtx_data      <= {K_FLAG, PRIM_IDLE};
      avtx_valid     <= 1'b0;
      frames_sent    <= '0;
      frames_aborted <= '0;
    end else begin
      avtx_valid <= 1'b1;
      if (avtx_ready) begin
        avtx_data <= link_active ? tx_word : state_data;
        if (!link_active && in_frame) begin
          frames_aborted <= frames_aborted + 32'd1;
          state          <= (state == ST_DATA && eop_word) ? ST_GAP : ST_DRAIN;
          gap            <= 16'(IDLE_GAP);
        end else begin
          case (state)
            ST_GAP: begin
              gap <= gap - 16'd1;
              if (gap == 16'd1) state <= sop_go ? ST_SOF : ST_IDLE;
            end
            ST_IDLE: if (sop_go) state <= ST_SOF;
            ST_SOF: begin
              crc   <= CRC_INIT;
              len   <= '0;
              state <= ST_DATA;
            end
            ST_DATA: begin
              if (!usertx_valid || over) begin
                // an overrunning last word ends the frame here; otherwise the tail must be drained
                frames_aborted <= frames_aborted + 32'd1;
                state          <= eop_word ? ST_GAP : ST_DRAIN;
                gap            <= 16'(IDLE_GAP);
              end else begin
                crc <= crc_next;
                len <= len + 32'd4;
                if (usertx_endofpacket) state <= ST_CRC;
              end
            end
            ST_CRC: state <= ST_EOF;
            ST_EOF: begin
              frames_sent <= frames_sent + 32'd1;
              state       <= ST_GAP;
              gap         <= 16'(IDLE_GAP);
            end
            ST_DRAIN: if (eop_word) begin
              state <= ST_GAP;
              gap   <= 16'(IDLE_GAP);
            end
            default: state <= ST_GAP;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_fc_tx_framer.sv
// tb_fc_tx_framer: table vectors, corner sequences and randomized frames against a stream model
module tb_fc_tx_framer;
  import fc_tx_framer_pkg::*;
  typedef logic [31:0] wq_t[$];
  typedef struct {
    int n;
    logic [31:0] base;
    logic [31:0] exp_crc;
  } vec_t;
  localparam logic [35:0] W_IDLE = {4'b1000, 32'hBC95B5B5};
  localparam logic [35:0] W_SOF  = {4'b1000, 32'hBCB55656};
  localparam logic [35:0] W_EOFN = {4'b1000, 32'hBC95D5D5};
  localparam logic [35:0] W_EOFA = {4'b1000, 32'hBC95F5F5};
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] usertx_data = '0;
  logic usertx_valid = 1'b0, sop = 1'b0, eop = 1'b0, link_active = 1'b1, avtx_ready = 1'b1;
  logic sel = 1'b0, rand_rdy = 1'b0;
  logic [35:0] state_data = 36'h0_00000000;
  logic rdy_a, rdy_b, val_a, val_b, urdy, val_s;
  logic [35:0] out_a, out_b, out_s;
  logic [31:0] sent_a, sent_b, ab_a, ab_b, sent_s, ab_s;
  logic [35:0] obs[$], exp_q[$];
  int checks = 0, failures = 0, exp_sent = 0, exp_ab = 0;
  vec_t vt[4];
  always #5 clk = ~clk;
  fc_tx_framer u_dut (
    .clk(clk), .reset(reset), .usertx_data(usertx_data), .usertx_valid(usertx_valid),
    .usertx_ready(rdy_a), .usertx_startofpacket(sop), .usertx_endofpacket(eop),
    .state_data(state_data), .link_active(link_active), .avtx_data(out_a), .avtx_valid(val_a),
    .avtx_ready(avtx_ready), .frames_sent(sent_a), .frames_aborted(ab_a));
  fc_tx_framer #(.MTU(16)) u_mtu (
    .clk(clk), .reset(reset), .usertx_data(usertx_data), .usertx_valid(usertx_valid),
    .usertx_ready(rdy_b), .usertx_startofpacket(sop), .usertx_endofpacket(eop),
    .state_data(state_data), .link_active(link_active), .avtx_data(out_b), .avtx_valid(val_b),
    .avtx_ready(avtx_ready), .frames_sent(sent_b), .frames_aborted(ab_b));
  assign urdy   = sel ? rdy_b : rdy_a;
  assign out_s  = sel ? out_b : out_a;
  assign val_s  = sel ? val_b : val_a;
  assign sent_s = sel ? sent_b : sent_a;
  assign ab_s   = sel ? ab_b : ab_a;
  always @(negedge clk) if (!reset && avtx_ready) obs.push_back(out_s);
  always @(posedge clk) if (rand_rdy) begin
    #1;
    avtx_ready = ($urandom_range(3) != 0);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // FC CRC-32 computed byte-wise from the polynomial definition
  function automatic logic [31:0] crc_ref(input wq_t w);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < w.size(); i++)
      for (int b = 3; b >= 0; b--) begin
        c = c ^ {24'h0, w[i][8*b +: 8]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    c = ~c;
    return {c[7:0], c[15:8], c[23:16], c[31:24]};
  endfunction
  function automatic wq_t mk(input int n, input logic [31:0] base, input bit rnd);
    wq_t w;
    for (int i = 0; i < n; i++) w.push_back(rnd ? $urandom() : base + 32'(i) * 32'h01010101);
    return w;
  endfunction
  task automatic exp_frame(input wq_t w, input int n, input bit abort);
    exp_q.push_back(W_SOF);
    for (int i = 0; i < n; i++) exp_q.push_back({4'b0000, w[i]});
    if (abort) begin
      exp_q.push_back(W_EOFA);
      exp_ab++;
    end else begin
      exp_q.push_back({4'b0000, crc_ref(w)});
      exp_q.push_back(W_EOFN);
      exp_sent++;
    end
  endtask
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_word(input logic [31:0] d, input logic s, input logic e);
    int n;
    logic ok;
    usertx_data = d; sop = s; eop = e; usertx_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = urdy;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout actual=%0d cycles required=accept", n);
    end
  endtask
  task automatic idle_in;
    usertx_valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask
  task automatic send_frame(input wq_t w);
    for (int i = 0; i < w.size(); i++) send_word(w[i], i == 0, i == w.size() - 1);
    idle_in();
  endtask
  task automatic send_underrun(input wq_t w, input int k);
    int t;
    for (int i = 0; i < k; i++) send_word(w[i], i == 0, 1'b0);
    idle_in();
    t = 0;
    while (out_s !== W_EOFA && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("underrun_eofa_seen", 64'(t < 200), 64'd1);
    for (int i = k; i < w.size(); i++) send_word(w[i], 1'b0, i == w.size() - 1);
    idle_in();
  endtask
  task automatic check_stream(input string name, input bit exact_gap);
    logic [35:0] nz[$];
    int gaps[$];
    int g;
    g = -1;
    foreach (obs[i]) begin
      if (obs[i] == W_IDLE) begin
        if (g >= 0) g++;
      end else begin
        if (g >= 0) gaps.push_back(g);
        nz.push_back(obs[i]);
        g = (obs[i] == W_EOFN || obs[i] == W_EOFA) ? 0 : -1;
      end
    end
    chk({name, "_len"}, 64'(nz.size()), 64'(exp_q.size()));
    for (int i = 0; i < nz.size() && i < exp_q.size(); i++) chk({name, "_word"}, 64'(nz[i]), 64'(exp_q[i]));
    foreach (gaps[i])
      if (exact_gap) chk({name, "_gap"}, 64'(gaps[i]), 64'd6);
      else chk({name, "_gap_min6"}, 64'(gaps[i] >= 6), 64'd1);
    obs.delete();
    exp_q.delete();
  endtask
  task automatic do_reset(input bit check_vals);
    reset = 1'b1; rand_rdy = 1'b0; link_active = 1'b1; avtx_ready = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (check_vals) begin
      chk("rst_avtx_valid", 64'(val_s), 64'd0);
      chk("rst_avtx_data", 64'(out_s), 64'(W_IDLE));
      chk("rst_usertx_ready", 64'(urdy), 64'd0);
      chk("rst_frames_sent", 64'(sent_s), 64'd0);
      chk("rst_frames_aborted", 64'(ab_s), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    obs.delete(); exp_q.delete();
    exp_sent = 0; exp_ab = 0;
  endtask
  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    wq_t w, w2;
    int n, k;
    vt[0] = '{1, 32'h00000000, 32'h1CDF4421};
    vt[1] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[2] = '{3, 32'h12345678, crc_ref(mk(3, 32'h12345678, 1'b0))};
    vt[3] = '{6, 32'hA0B1C2D3, crc_ref(mk(6, 32'hA0B1C2D3, 1'b0))};
    // reset state and idle stream
    do_reset(1'b1);
    @(posedge clk);
    #1;
    chk("valid_after_reset", 64'(val_s), 64'd1);
    settle(10);
    chk("reset_idle_words", 64'(obs.size() >= 6), 64'd1);
    check_stream("reset", 1'b0);
    // table of single frames with known CRC words
    for (int i = 0; i < 4; i++) begin
      w = mk(vt[i].n, vt[i].base, 1'b0);
      send_frame(w);
      exp_q.push_back(W_SOF);
      foreach (w[j]) exp_q.push_back({4'b0000, w[j]});
      exp_q.push_back({4'b0000, vt[i].exp_crc});
      exp_q.push_back(W_EOFN);
      exp_sent++;
      settle(20);
      check_stream("table", 1'b0);
      chk("table_frames_sent", 64'(sent_s), 64'(exp_sent));
    end
    // back-to-back frames with valid held high
    w = mk(7, 32'h11111111, 1'b0);
    w2 = mk(7, 32'h22222222, 1'b0);
    send_frame(w);
    send_frame(w2);
    exp_frame(w, 7, 1'b0);
    exp_frame(w2, 7, 1'b0);
    settle(20);
    check_stream("b2b", 1'b1);
    // underrun after word 3 of 10, then a normal frame
    w = mk(10, 32'h30303030, 1'b0);
    send_underrun(w, 3);
    exp_frame(w, 3, 1'b1);
    w2 = mk(2, 32'h40404040, 1'b0);
    send_frame(w2);
    exp_frame(w2, 2, 1'b0);
    settle(20);
    check_stream("underrun", 1'b0);
    chk("underrun_aborted", 64'(ab_s), 64'(exp_ab));
    // PCS backpressure in the middle of a frame
    w = mk(6, 32'h50505050, 1'b0);
    send_word(w[0], 1'b1, 1'b0);
    send_word(w[1], 1'b0, 1'b0);
    avtx_ready = 1'b0;
    usertx_data = w[2]; usertx_valid = 1'b1; sop = 1'b0; eop = 1'b0;
    begin
      logic [35:0] held;
      @(negedge clk);
      held = out_s;
      repeat (5) begin
        @(negedge clk);
        chk("stall_data_held", 64'(out_s), 64'(held));
        chk("stall_no_ready", 64'(urdy), 64'd0);
        @(posedge clk);
        #1;
      end
    end
    avtx_ready = 1'b1;
    for (int i = 2; i < 6; i++) send_word(w[i], 1'b0, i == 5);
    idle_in();
    exp_frame(w, 6, 1'b0);
    settle(20);
    check_stream("stall", 1'b0);
    // link loss mid-frame
    w = mk(4, 32'h60606060, 1'b0);
    send_word(w[0], 1'b1, 1'b0);
    send_word(w[1], 1'b0, 1'b0);
    state_data = 36'h5_A5A5A5A5;
    usertx_data = w[2]; usertx_valid = 1'b1;
    link_active = 1'b0;
    @(negedge clk);
    chk("linkdown_ready", 64'(urdy), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("linkdown_state_word", 64'(out_s), 64'h5_A5A5A5A5);
    @(posedge clk);
    #1;
    chk("linkdown_aborted", 64'(ab_s), 64'(exp_ab + 1));
    exp_ab++;
    link_active = 1'b1;
    send_word(w[3], 1'b0, 1'b1);
    idle_in();
    settle(20);
    obs.delete();
    w2 = mk(3, 32'h70707070, 1'b0);
    send_frame(w2);
    exp_frame(w2, 3, 1'b0);
    settle(20);
    check_stream("after_linkdown", 1'b0);
    // randomized frames, underruns and stray words with random PCS ready
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(1, 12);
      w = mk(n, 32'h0, 1'b1);
      if ($urandom_range(4) == 0) begin
        send_word($urandom(), 1'b0, 1'b0);
        idle_in();
      end
      if (n >= 2 && $urandom_range(5) == 0) begin
        k = $urandom_range(1, n - 1);
        send_underrun(w, k);
        exp_frame(w, k, 1'b1);
      end else begin
        send_frame(w);
        exp_frame(w, n, 1'b0);
      end
      settle($urandom_range(0, 3));
    end
    rand_rdy = 1'b0;
    settle(2);
    avtx_ready = 1'b1;
    settle(40);
    check_stream("random", 1'b0);
    chk("random_frames_sent", 64'(sent_s), 64'(exp_sent));
    chk("random_frames_aborted", 64'(ab_s), 64'(exp_ab));
    // MTU of 16 bytes on the second instance
    sel = 1'b1;
    do_reset(1'b0);
    w = mk(5, 32'h80808080, 1'b0);
    send_frame(w);
    exp_frame(w, 4, 1'b1);
    w2 = mk(4, 32'h90909090, 1'b0);
    send_frame(w2);
    exp_frame(w2, 4, 1'b0);
    settle(20);
    check_stream("mtu", 1'b0);
    chk("mtu_frames_sent", 64'(sent_s), 64'd1);
    chk("mtu_frames_aborted", 64'(ab_s), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
